la_debounce: RTL

- Sequential qualifier that consumes a combinational or-and gate output (typically an la_oa32 z net combining several asynchronous request/fault conditions).
- Synchronizes the level into the clk domain and rejects glitches. It updates a clean level output only after the input has held a new value for a programmable number of cycles.
- Emits one-cycle rise/fall event pulses.
- Sits between stdlib gate logic and control FSMs or interrupt logic.

---
 rtl/la_debounce_pkg.sv | 10 +
 rtl/la_debounce_dsync.sv | 39 +++
 rtl/la_debounce.sv | 110 +++++++++++
 3 files changed

// File: rtl/la_debounce_pkg.sv
// Shared types for the la_debounce level qualifier.
// Holds the two-state FSM encoding used by the top.
package la_debounce_pkg;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_e;

endpackage

// File: rtl/la_debounce_dsync.sv
// la_dsync: multi-stage level synchronizer with asynchronous active-high reset.
// Every stage resets to RSTVAL so the downstream filter sees a known level.
module la_dsync #(
    parameter string PROP   = "DEFAULT",
    parameter int    STAGES = 2,
    parameter bit    RSTVAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);

    logic [STAGES-1:0] r_sync;

    // Technology-specific variants currently map onto the same generic flop chain.
    generate
        if (PROP == "DEFAULT") begin : g_generic
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= {STAGES{RSTVAL}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], in};
                end
            end
        end else begin : g_mapped
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_sync <= {STAGES{RSTVAL}};
                end else begin
                    r_sync <= {r_sync[STAGES-2:0], in};
                end
            end
        end
    endgenerate

    assign out = r_sync[STAGES-1];

endmodule

// File: rtl/la_debounce.sv
// la_debounce: synchronizes an asynchronous level, qualifies it for thresh+2
// stable cycles, and publishes a clean level with one-cycle rise/fall pulses.
//
// state     | meaning
// ST_STABLE | z matches the synchronized input, nothing pending
// ST_CHECK  | synchronized input differs from z, counting stable cycles
module la_debounce
    import la_debounce_pkg::*;
#(
    parameter string PROP       = "DEFAULT",
    parameter int    SYNCSTAGES = 2,
    parameter int    CNTW       = 8,
    parameter bit    RSTVAL     = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [CNTW-1:0] thresh,
    input  logic            in,
    output logic            z,
    output logic            rise,
    output logic            fall,
    output logic            busy
);

    logic            w_s;
    state_e          r_state;
    state_e          w_state_nxt;
    logic [CNTW-1:0] r_cnt;
    logic [CNTW-1:0] w_cnt_nxt;
    logic            r_z;
    logic            w_z_nxt;
    logic            r_rise;
    logic            w_rise_nxt;
    logic            r_fall;
    logic            w_fall_nxt;

    la_dsync #(
        .PROP   (PROP),
        .STAGES (SYNCSTAGES),
        .RSTVAL (RSTVAL)
    ) u_dsync (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .out   (w_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_z     <= RSTVAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_z     <= w_z_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The >= compare lets a lowered thresh finish the qualification immediately
    // and keeps cnt from ever wrapping, even with thresh at all-ones.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_z_nxt     = r_z;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        if (en) begin
            case (r_state)
                ST_STABLE: begin
                    if (w_s != r_z) begin
                        w_state_nxt = ST_CHECK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_CHECK: begin
                    if (w_s == r_z) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt >= thresh) begin
                        w_state_nxt = ST_STABLE;
                        w_cnt_nxt   = '0;
                        w_z_nxt     = w_s;
                        w_rise_nxt  = w_s;
                        w_fall_nxt  = ~w_s;
                    end else begin
                        w_cnt_nxt = r_cnt + CNTW'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_comb begin
        z    = r_z;
        rise = r_rise;
        fall = r_fall;
        busy = (r_state == ST_CHECK);
    end

endmodule
